div_clk_monitor: RTL
====================

Name: div_clk_monitor

Overview:
Downstream checker for the even-ratio divided clock (divide-by-six output, toggling every 3 sys_clk cycles).
- Samples the divided clock as data in the sys_clk domain and emits a one-cycle tick per rising edge.
- Measures each period in sys_clk cycles and declares lock after consecutive in-tolerance periods.
- Flags bad periods and stalls.
- Downstream logic uses tick as a clock enable instead of clocking on the divided signal.

Parameters:
- EXP_PERIOD, 6: expected period in sys_clk cycles.
- TOL, 0: allowed deviation, in cycles. A period is good when |period - EXP_PERIOD| <= TOL.
- LOCK_N, 4: consecutive good periods required to lock (>= 1).
- TIMEOUT, 24: cycles without a rising edge before a stall is declared. Must satisfy TIMEOUT < 2^CNT_W - 1.
- CNT_W, 8: width of the period counter and of the period output.

Ports:
- sys_clk, input, 1: system clock.
- sys_rst_n, input, 1: asynchronous active-low reset.
- clk_div_in, input, 1: divided clock from the divider, treated as asynchronous data.
- tick, output, 1: one-cycle pulse per detected rising edge.
- period, output, CNT_W: last measured period.
- period_vld, output, 1: one-cycle pulse when period updates.
- locked, output, 1: lock status.
- err_pulse, output, 1: one-cycle pulse on a bad period or timeout.
- err_cnt, output, 8: saturating error event count.

Behaviour:
- Reset (asynchronous, sys_rst_n low): all outputs 0, both sync flops 0, run_cnt 0, good_cnt 0, state IDLE. A reset during lock drops locked immediately.
- Synchronizer: 2-flop sync (s1, s2) plus a history flop s3. rise = s2 & ~s3.
- tick is registered from rise. Latency: tick is high for one cycle, starting 3 sys_clk edges after the first edge that samples clk_div_in high.
- Counter run_cnt:
  - On rise: run_cnt <= 0.
  - Otherwise: increment, saturating at 2^CNT_W - 1.
  - Measured value is m = run_cnt + 1, so a divide-by-six input gives m = 6.
- Measurement update: on rise in states ACQ or LOCK, period <= m and period_vld pulses. On the first rise from IDLE there is no measurement (no prior edge).
- FSM (state register with async reset):
  - IDLE, on rise: -> ACQ, good_cnt <= 0.
  - ACQ, rise with m good: good_cnt++. If good_cnt == LOCK_N - 1 -> LOCK.
  - ACQ, rise with m bad: stay in ACQ, good_cnt <= 0, err_pulse.
  - LOCK, rise with m bad: -> ACQ, good_cnt <= 0, err_pulse.
  - LOCK, rise with m good: stay in LOCK.
  - ACQ or LOCK, no rise and run_cnt == TIMEOUT: -> IDLE, err_pulse.
- locked is registered and equals (next_state == LOCK), so it rises the cycle after the locking rise is evaluated.
- Simultaneous rise and timeout in the same cycle: the rise wins. m = TIMEOUT + 1 is judged as a normal period (bad for the defaults).
- Timeout fires once per stall. run_cnt keeps counting in IDLE but IDLE never raises a timeout.
- err_cnt increments on each err_pulse and saturates at 255. Only reset clears it.
- Glitches shorter than one sys_clk cycle may be missed; no requirement applies to them.

Decomposition:
- Shared package holds:
  - State encoding: IDLE = 2'd0, ACQ = 2'd1, LOCK = 2'd2.
  - Default constants: EXP_PERIOD, TIMEOUT.
- One sub-module: sync_rise_det. It contains the 2-flop synchronizer, the history flop and rise detection, and outputs rise.
- Everything else stays in div_clk_monitor.

Test Plan:
1. Divide-by-six source attached after reset:
   - 1st tick: enters ACQ, no period_vld.
   - Ticks 2–5: period = 6 with period_vld.
   - locked = 1 the cycle after the 5th rise is evaluated; err_cnt = 0.
   - Ticks then continue every 6 cycles.
2. While locked, one period stretched to 7 (TOL = 0):
   - period = 7, err_pulse, locked = 0, err_cnt = 1.
   - Relock after 4 further good periods.
3. Rerun with TOL = 1 and alternating periods 5/7: lock is reached and err_cnt stays 0.
4. Hold clk_div_in low while locked:
   - Exactly 24 cycles after the last rise: err_pulse, locked = 0, state IDLE.
   - No further err_pulse while held low.
   - Next rise goes to ACQ with no period_vld.
5. Force the rise to coincide with run_cnt == TIMEOUT: a single err_pulse from the bad period (m = 25), state ACQ, not IDLE.
6. Assert sys_rst_n low mid-lock, asynchronously between clock edges:
   - locked, tick, period and err_cnt go to 0 immediately.
   - After release, the source from scenario 1 locks again at the 5th rise.

Source files
------------

// File: rtl/div_clk_monitor_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_clk_monitor_pkg : shared state encoding and default timing constants
// Revision 1.0
// ---------------------------------------------------------------------------
package div_clk_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  localparam int EXP_PERIOD = 6;
  localparam int TIMEOUT    = 24;

endpackage
`default_nettype wire

// File: rtl/div_clk_monitor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_clk_monitor_if : divided-clock input and monitor status outputs
// Revision 1.0
// ---------------------------------------------------------------------------
interface div_clk_monitor_if #(
  parameter int CNT_W = 8
) ();

  logic             clk_div_in;
  logic             tick;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic             err_pulse;
  logic [7:0]       err_cnt;

  modport master (
    output clk_div_in,
    input  tick, period, period_vld, locked, err_pulse, err_cnt
  );

  modport slave (
    input  clk_div_in,
    output tick, period, period_vld, locked, err_pulse, err_cnt
  );

endinterface
`default_nettype wire

// File: rtl/div_clk_monitor_sync_rise_det.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_rise_det : 2-flop synchronizer plus history flop, flags rising edges
// Revision 1.0
// ---------------------------------------------------------------------------
module sync_rise_det (
  input  wire logic sys_clk,
  input  wire logic sys_rst_n,
  input  wire logic d_i,
  output logic      rise_o
);

  import div_clk_monitor_pkg::*;

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule
`default_nettype wire

// File: rtl/div_clk_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_clk_monitor : period measurement, lock and stall detection for a divided clock
// Revision 1.0
// ---------------------------------------------------------------------------
module div_clk_monitor #(
  parameter int EXP_PERIOD = div_clk_monitor_pkg::EXP_PERIOD,
  parameter int TOL        = 0,
  parameter int LOCK_N     = 4,
  parameter int TIMEOUT    = div_clk_monitor_pkg::TIMEOUT,
  parameter int CNT_W      = 8
) (
  input wire logic         sys_clk,
  input wire logic         sys_rst_n,
  div_clk_monitor_if.slave mon
);

  import div_clk_monitor_pkg::*;

  localparam int               GOOD_W  = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]      LO_LIM  = (EXP_PERIOD > TOL) ? 32'(EXP_PERIOD - TOL) : 32'd0;
  localparam logic [31:0]      HI_LIM  = 32'(EXP_PERIOD + TOL);

  state_e            state_q;
  logic [GOOD_W-1:0] good_cnt_q;
  logic [CNT_W-1:0]  run_cnt_q;
  logic              tick_q;
  logic [CNT_W-1:0]  period_q;
  logic              period_vld_q;
  logic              locked_q;
  logic              err_pulse_q;
  logic [7:0]        err_cnt_q;

  logic              rise;
  logic [31:0]       meas;
  logic              meas_good;
  logic              tracking;
  logic              stall;
  logic              err_evt;

  sync_rise_det u_sync_rise_det (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .d_i       (mon.clk_div_in),
    .rise_o    (rise)
  );

  // The edge that restarts the counter is itself one cycle of the period.
  assign meas      = 32'(run_cnt_q) + 32'd1;
  assign meas_good = (meas >= LO_LIM) && (meas <= HI_LIM);
  assign tracking  = (state_q == ACQ) || (state_q == LOCK);
  assign stall     = tracking && !rise && (run_cnt_q == CNT_W'(TIMEOUT));
  assign err_evt   = (tracking && rise && !meas_good) || stall;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      good_cnt_q   <= '0;
      run_cnt_q    <= '0;
      tick_q       <= 1'b0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      tick_q       <= rise;
      period_vld_q <= 1'b0;
      locked_q     <= 1'b0;
      err_pulse_q  <= err_evt;

      if (rise) begin
        run_cnt_q <= '0;
      end else if (run_cnt_q != CNT_MAX) begin
        run_cnt_q <= run_cnt_q + CNT_W'(1);
      end

      if (rise && tracking) begin
        period_q     <= (meas > 32'(CNT_MAX)) ? CNT_MAX : meas[CNT_W-1:0];
        period_vld_q <= 1'b1;
      end

      if (err_evt && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end

      // locked mirrors the state being entered this cycle.
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q    <= ACQ;
            good_cnt_q <= '0;
          end
        end
        ACQ: begin
          if (rise) begin
            if (!meas_good) begin
              good_cnt_q <= '0;
            end else if (good_cnt_q == GOOD_W'(LOCK_N - 1)) begin
              state_q  <= LOCK;
              locked_q <= 1'b1;
            end else begin
              good_cnt_q <= good_cnt_q + GOOD_W'(1);
            end
          end else if (stall) begin
            state_q <= IDLE;
          end
        end
        LOCK: begin
          locked_q <= 1'b1;
          if (rise && !meas_good) begin
            state_q    <= ACQ;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
          end else if (stall) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mon.tick       = tick_q;
  assign mon.period     = period_q;
  assign mon.period_vld = period_vld_q;
  assign mon.locked     = locked_q;
  assign mon.err_pulse  = err_pulse_q;
  assign mon.err_cnt    = err_cnt_q;

endmodule
`default_nettype wire
